// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU control path: ALUCtrl encodings, RV64I
//   opcode / funct3 / funct7 constants used by the decoder, the immediate
//   format selector and the packed record held in the decoder's output
//   register. The ALU imports the same ALUCtrl encodings.
package alu_pkg;

    // ALUCtrl encodings
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // Major opcodes
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // funct3 values
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_SD  = 3'b011;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_I    = 2'd1,
        IMM_S    = 2'd2,
        IMM_B    = 2'd3
    } imm_sel_e;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic        src;
        logic [63:0] imm;
        logic        illegal;
    } dec_op_t;

endpackage

// File: rtl/alu_op_decoder_if.sv
// alu_op_decoder_if
//   Bundles the instruction-side and operation-side handshakes of the ALU
//   operation decoder.
//   master : upstream/downstream side (drives InstrValid, Instruction, OpReady)
//   slave  : the decoder (drives InstrReady, OpValid and the decoded fields)
interface alu_op_decoder_if;
    logic        InstrValid;
    logic [31:0] Instruction;
    logic        InstrReady;
    logic        OpValid;
    logic        OpReady;
    logic [3:0]  ALUCtrl;
    logic        ALUSrc;
    logic [63:0] signExtend;
    logic        Illegal;
    logic [15:0] IllegalCount;

    modport master (
        output InstrValid, Instruction, OpReady,
        input  InstrReady, OpValid, ALUCtrl, ALUSrc, signExtend, Illegal, IllegalCount
    );

    modport slave (
        input  InstrValid, Instruction, OpReady,
        output InstrReady, OpValid, ALUCtrl, ALUSrc, signExtend, Illegal, IllegalCount
    );
endinterface

// File: rtl/alu_imm_gen.sv
// alu_imm_gen
//   Purely combinational extraction of the I, S and B immediates from a
//   32-bit instruction, each sign-extended to 64 bits from instr[31].
//   instr  in  32  raw instruction word
//   imm_i  out 64  sext(instr[31:20])
//   imm_s  out 64  sext({instr[31:25], instr[11:7]})
//   imm_b  out 64  sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
module alu_imm_gen (
    input  logic [31:0] instr,
    output logic [63:0] imm_i,
    output logic [63:0] imm_s,
    output logic [63:0] imm_b
);

    assign imm_i = {{52{instr[31]}}, instr[31:20]};
    assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    // rs1, funct3 and opcode fields carry no immediate bits
    logic unused_fields;
    assign unused_fields = ^{instr[19:12], instr[6:0]};

endmodule

// File: rtl/alu_op_decoder.sv
// alu_op_decoder
//   Registered decode stage in front of the ALU operand mux. Accepts one
//   RV64I instruction per cycle and holds the decoded ALUCtrl, ALUSrc,
//   sign-extended immediate and Illegal flag in a one-entry output register.
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset
//   bus    slave modport of alu_op_decoder_if (instruction handshake in,
//          operation handshake and decoded fields out)
//   Optional feature: define ALU_DEC_ILLEGAL_CNT_EN to build the saturating
//   16-bit counter of accepted illegal instructions; otherwise IllegalCount
//   is tied to 0.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    alu_op_decoder_if.slave   bus
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0] state_reg, state_next;
    dec_op_t    op_reg;
    dec_op_t    dec;
    imm_sel_e   imm_sel;
    logic       accept;
    logic [63:0] imm_i, imm_s, imm_b;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    assign opcode = bus.Instruction[6:0];
    assign funct3 = bus.Instruction[14:12];
    assign funct7 = bus.Instruction[31:25];

    alu_imm_gen u_imm_gen (
        .instr (bus.Instruction),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_b (imm_b)
    );

    // Opcode decode; anything not matched stays at the illegal default.
    always_comb begin
        dec         = '0;
        dec.ctrl    = ALU_ADD;
        dec.illegal = 1'b1;
        imm_sel     = IMM_NONE;
        unique case (opcode)
            OP_RTYPE: begin
                if (funct7 == F7_BASE && funct3 == F3_ADD) begin
                    dec.ctrl = ALU_ADD; dec.illegal = 1'b0;
                end else if (funct7 == F7_BASE && funct3 == F3_AND) begin
                    dec.ctrl = ALU_AND; dec.illegal = 1'b0;
                end else if (funct7 == F7_BASE && funct3 == F3_OR) begin
                    dec.ctrl = ALU_OR; dec.illegal = 1'b0;
                end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
                    dec.ctrl = ALU_SUB; dec.illegal = 1'b0;
                end
            end
            OP_ITYPE: begin
                if (funct3 == F3_ADD || funct3 == F3_AND || funct3 == F3_OR) begin
                    dec.ctrl    = (funct3 == F3_AND) ? ALU_AND :
                                  (funct3 == F3_OR)  ? ALU_OR  : ALU_ADD;
                    dec.src     = 1'b1;
                    dec.illegal = 1'b0;
                    imm_sel     = IMM_I;
                end
            end
            OP_LOAD: begin
                if (funct3 == F3_LD) begin
                    dec.src = 1'b1; dec.illegal = 1'b0; imm_sel = IMM_I;
                end
            end
            OP_STORE: begin
                if (funct3 == F3_SD) begin
                    dec.src = 1'b1; dec.illegal = 1'b0; imm_sel = IMM_S;
                end
            end
            OP_BRANCH: begin
                // Operands compared through the ALU; immediate feeds the PC adder.
                if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                    dec.ctrl = ALU_SUB; dec.illegal = 1'b0; imm_sel = IMM_B;
                end
            end
            default: ;
        endcase
        case (imm_sel)
            IMM_I:   dec.imm = imm_i;
            IMM_S:   dec.imm = imm_s;
            IMM_B:   dec.imm = imm_b;
            default: dec.imm = '0;
        endcase
    end

    assign bus.InstrReady = (state_reg == ST_EMPTY) || bus.OpReady;
    assign accept         = bus.InstrValid && bus.InstrReady;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: if (accept) state_next = ST_FULL;
            ST_FULL:  if (bus.OpReady && !accept) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_EMPTY;
            op_reg.ctrl    <= ALU_ADD;
            op_reg.src     <= 1'b0;
            op_reg.imm     <= '0;
            op_reg.illegal <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) op_reg <= dec;
        end
    end

    assign bus.OpValid    = (state_reg == ST_FULL);
    assign bus.ALUCtrl    = op_reg.ctrl;
    assign bus.ALUSrc     = op_reg.src;
    assign bus.signExtend = op_reg.imm;
    assign bus.Illegal    = op_reg.illegal;

`ifdef ALU_DEC_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt_reg;
    always_ff @(posedge clk) begin
        if (reset)
            illegal_cnt_reg <= '0;
        else if (accept && dec.illegal && illegal_cnt_reg != 16'hFFFF)
            illegal_cnt_reg <= illegal_cnt_reg + 16'd1;
    end
    assign bus.IllegalCount = illegal_cnt_reg;
`else
    assign bus.IllegalCount = 16'd0;
`endif

endmodule
